muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit in the execute stage that produces the HI/LO write stream for the hilo register pair. It accepts one MULT/MULTU/DIV/DIVU operation at a time through a valid/ready handshake, iterates radix-2 over 32 steps, then issues one cycle of hi_write/lo_write with the 64-bit result. It is the writer for the hilo block's hi_write/lo_write/hi_data/lo_data inputs.

---
 rtl/muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide for the execute stage.
// It takes one MULT/MULTU/DIV/DIVU at a time, iterates radix-2 over 32
// steps, and then issues a single-cycle HI/LO write to the hilo register
// pair.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   When defined, MULT/MULTU use a single-cycle multiplier at accept and
//   write in the next cycle. Divide is unchanged.
//   When undefined, multiply runs the same 32-step iterative path as divide.
//
// Ports:
//   clk        clock; all state changes on posedge
//   resetn     synchronous active-low reset
//   valid      operation request
//   op         2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
//   a, b       rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   flush      cancel the in-flight operation; no write is produced
//   ready      high only in IDLE
//   done       one-cycle completion pulse, gated by !flush
//   hi_write   hilo write strobe for HI (equals done)
//   lo_write   hilo write strobe for LO (equals done)
//   hi_data    upper product or remainder; valid while done
//   lo_data    lower product or quotient; valid while done
//   dbg_state  current FSM state, for observation only
//
// Handshake: a request transfers on a posedge where valid & ready & !flush.
// ready is high only in IDLE. valid while ready is low is ignored.
// Operands are captured at the transfer and need not be held afterwards.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             done,
  output logic             hi_write,
  output logic             lo_write,
  output logic [WIDTH-1:0] hi_data,
  output logic [WIDTH-1:0] lo_data,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [5:0]         step;
  logic               op_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  // Multiply: multiplicand. Divide: divisor.
  logic [WIDTH-1:0]   operand;
  // Multiply: {partial product, multiplier}.
  // Divide:   {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_fits;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;

  always_comb begin
    fast_prod = '0;
    if (op[0]) begin
      fast_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end else begin
      fast_prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    end
  end
`endif

  // op[0] == 0 selects the signed variants. Those work on magnitudes and
  // fix the sign of the result at the end.
  always_comb begin
    a_abs = (!op[0] && a[WIDTH-1]) ? -a : a;
    b_abs = (!op[0] && b[WIDTH-1]) ? -b : b;
  end

  // One radix-2 step of either the shift-add multiply or the restoring
  // divide. Both operate on the shared accumulator.
  always_comb begin
    mul_add   = acc[0] ? operand : '0;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_fits  = div_shift >= {1'b0, operand};
    // When the divisor fits, the difference is below 2^32, so the low
    // 32 bits hold the complete value.
    div_diff  = div_shift[WIDTH-1:0] - operand;
    if (op_div) begin
      acc_next = {(div_fits ? div_diff : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_fits};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the value produced by the final step.
  // Divide by zero: the quotient is forced to all ones. The remainder
  // path reproduces the original dividend on its own, because every step
  // "fits" and the negation restores the sign of a.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (op_div) begin
      res_hi = neg_r ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
      if (div_zero) begin
        res_lo = '1;
      end else begin
        res_lo = neg_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
      end
    end else begin
      {res_hi, res_lo} = neg_q ? -acc_next : acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      step     <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      operand  <= '0;
      acc      <= '0;
      hi_data  <= '0;
      lo_data  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      step  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid) begin
            op_div   <= op[1];
            neg_q    <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= !op[0] && a[WIDTH-1];
            div_zero <= op[1] && (b == '0);
            operand  <= op[1] ? b_abs : a_abs;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
            step     <= '0;
`ifdef MULDIV_FAST_MUL_EN
            if (!op[1]) begin
              {hi_data, lo_data} <= fast_prod;
              state              <= S_DONE;
            end else begin
              state <= S_BUSY;
            end
`else
            state <= S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          acc  <= acc_next;
          step <= step + 6'd1;
          if (step == 6'(WIDTH - 1)) begin
            hi_data <= res_hi;
            lo_data <= res_lo;
            step    <= '0;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = (state == S_IDLE);
  assign done      = (state == S_DONE) && !flush;
  assign hi_write  = done;
  assign lo_write  = done;
  assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit. Random and directed operations are checked
// against an arithmetic reference model: native 64-bit multiply, divide
// and modulo.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        ready;
  logic        done;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int write_cnt = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .a(a), .b(b),
    .flush(flush), .ready(ready), .done(done), .hi_write(hi_write),
    .lo_write(lo_write), .hi_data(hi_data), .lo_data(lo_data),
    .dbg_state(dbg_state)
  );

  // Clock and write-strobe monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hi_write === 1'b1 || lo_write === 1'b1) write_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  // Reference model: {hi, lo}
  function automatic logic [63:0] ref_model(input logic [1:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] r;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    r = '0;
    case (o)
      2'b00: r = sx * sy;
      2'b01: r = ux * uy;
      2'b10: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          r = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else begin
          uq = ux / uy;
          ur = ux % uy;
          r = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Driver: issue one operation and check its completion.
  // The caller is 1 time unit after a posedge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input string name);
    int n;
    int w;
    int exp_lat;
    bit got;
    exp_lat = o[1] ? DIV_LAT : MUL_LAT;
    w = 0;
    while (ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    n_checks++;
    if (ready !== 1'b1) $display("FAIL %s ready_wait: ready=%b required 1", name, ready);
    else n_pass++;
    valid = 1'b1; op = o; a = x; b = y;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        valid = 1'b0; a = $urandom; b = $urandom;
      end
      if (done === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got || n != exp_lat)
      $display("FAIL %s latency: got=%0d cycles (seen=%0d) required %0d", name, n, got, exp_lat);
    else n_pass++;
    n_checks++;
    if (hi_data !== exp_hi) $display("FAIL %s hi: got=%h required %h", name, hi_data, exp_hi);
    else n_pass++;
    n_checks++;
    if (lo_data !== exp_lo) $display("FAIL %s lo: got=%h required %h", name, lo_data, exp_lo);
    else n_pass++;
    n_checks++;
    if ({hi_write, lo_write} !== 2'b11)
      $display("FAIL %s strobes: got=%b%b required 11", name, hi_write, lo_write);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({done, ready, hi_data, lo_data} !== {1'b0, 1'b1, exp_hi, exp_lo})
      $display("FAIL %s after_done: done=%b ready=%b hi=%h lo=%h required 0 1 %h %h",
               name, done, ready, hi_data, lo_data, exp_hi, exp_lo);
    else n_pass++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; valid = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ready, done, hi_write, lo_write, hi_data, lo_data} !== {1'b1, 3'b000, 64'h0})
      $display("FAIL reset_state: ready=%b done=%b hw=%b lw=%b hi=%h lo=%h required 1 0 0 0 0 0",
               ready, done, hi_write, lo_write, hi_data, lo_data);
    else n_pass++;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5");
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    do_op(2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        "divu_100by7");
    do_op(2'b11, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, "divu_by_zero");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, "div_overflow");
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF, "div_neg_by_zero");
    do_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, "div_7by_neg2");
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'h0;
        1:       y = $urandom_range(1, 15);
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      e = ref_model(o, x, y);
      do_op(o, x, y, e[63:32], e[31:0], "random");
    end
  endtask

  task automatic test_flush();
    int w0;
    w0 = write_cnt;
    // Flush in BUSY, 10 cycles after accept
    valid = 1'b1; op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    n_checks++;
    if ({done, hi_write, lo_write} !== 3'b000)
      $display("FAIL flush_busy_strobes: got=%b%b%b required 000", done, hi_write, lo_write);
    else n_pass++;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (ready !== 1'b1) $display("FAIL flush_busy_ready: ready=%b required 1", ready);
    else n_pass++;
    // valid together with flush in IDLE is not accepted
    valid = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    n_checks++;
    if (ready !== 1'b1) $display("FAIL flush_idle_accept: ready=%b required 1", ready);
    else n_pass++;
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (write_cnt !== w0) $display("FAIL flush_no_write: writes=%0d required %0d", write_cnt - w0, 0);
    else n_pass++;
    do_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, "multu_after_flush");
    // Flush sampled in DONE suppresses the strobes in that cycle
    w0 = write_cnt;
    valid = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (DIV_LAT - 1) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    n_checks++;
    if ({done, hi_write, lo_write} !== 3'b000)
      $display("FAIL flush_done_strobes: got=%b%b%b required 000", done, hi_write, lo_write);
    else n_pass++;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || write_cnt !== w0)
      $display("FAIL flush_done_after: ready=%b writes=%0d required 1 0", ready, write_cnt - w0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w0;
    do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "multu_before_reset");
    w0 = write_cnt;
    valid = 1'b1; op = 2'b10; a = 32'd12345; b = 32'd67;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    n_checks++;
    if ({ready, done, hi_write, lo_write, hi_data, lo_data} !== {1'b1, 3'b000, 64'h0})
      $display("FAIL reset_mid_state: ready=%b done=%b hw=%b lw=%b hi=%h lo=%h required 1 0 0 0 0 0",
               ready, done, hi_write, lo_write, hi_data, lo_data);
    else n_pass++;
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (write_cnt !== w0 || ready !== 1'b1)
      $display("FAIL reset_mid_no_write: writes=%0d ready=%b required 0 1", write_cnt - w0, ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    int t1;
    int t2;
    logic [63:0] e1;
    logic [63:0] e2;
    logic [63:0] r1;
    logic [63:0] r2;
    e1 = ref_model(2'b11, 32'd1000, 32'd3);
    e2 = ref_model(2'b10, 32'hFFFF_FFF9, 32'd2);
    t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    valid = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    n = 0;
    while (t2 < 0 && n < 100) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2;
      end
      if (done === 1'b1) begin
        if (t1 < 0) begin
          t1 = n; r1 = {hi_data, lo_data};
        end else begin
          t2 = n; r2 = {hi_data, lo_data};
        end
      end
    end
    valid = 1'b0;
    n_checks++;
    if (t1 != DIV_LAT) $display("FAIL b2b_first_latency: got=%0d required %0d", t1, DIV_LAT);
    else n_pass++;
    n_checks++;
    if (r1 !== e1) $display("FAIL b2b_first_result: got=%h required %h", r1, e1);
    else n_pass++;
    n_checks++;
    if (t2 != DIV_LAT + 34) $display("FAIL b2b_second_latency: got=%0d required %0d", t2, DIV_LAT + 34);
    else n_pass++;
    n_checks++;
    if (r2 !== e2) $display("FAIL b2b_second_result: got=%h required %h", r2, e2);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
